// File: rtl/eth_regs_pkg.sv
// eth_regs_pkg: register offsets, response codes, state types and the byte-merge helper shared by the MAC register file and eth_controller
package eth_regs_pkg;
   localparam logic [11:0] UWA0_OFS = 12'h700;
   localparam logic [11:0] UWA1_OFS = 12'h704;
   localparam logic [11:0] CTRL_OFS = 12'h708;
   localparam logic [11:0] STAT_OFS = 12'h70C;
   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam int CTRL_RX_BIT = 0;
   localparam int CTRL_TX_BIT = 1;
   typedef enum logic {W_IDLE, W_RESP} wr_state_t;
   typedef enum logic {R_IDLE, R_DATA} rd_state_t;
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] strb);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
      return r;
   endfunction
endpackage

// File: rtl/axil_wr_capture.sv
// axil_wr_capture: holds AXI-Lite AW and W independently and issues a one-cycle commit once both are held
module axil_wr_capture (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [11:0] awaddr,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   input  logic        wvalid,
   output logic        wready,
   input  logic        busy,
   output logic        commit,
   output logic [11:0] addr,
   output logic [31:0] data,
   output logic [3:0]  strb
);
   logic aw_held, w_held;
   assign awready = aresetn && awvalid && !aw_held && !busy;
   assign wready = aresetn && wvalid && !w_held && !busy;
   assign commit = aw_held && w_held;
   // latch each channel on its own handshake; both holders empty together on commit
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         aw_held <= 1'b0;
         w_held <= 1'b0;
         addr <= '0;
         data <= '0;
         strb <= '0;
      end else begin
         if (awready) begin
            aw_held <= 1'b1;
            addr <= awaddr;
         end else if (commit) aw_held <= 1'b0;
         if (wready) begin
            w_held <= 1'b1;
            data <= wdata;
            strb <= wstrb;
         end else if (commit) w_held <= 1'b0;
      end
endmodule

// File: rtl/eth_mac_regs.sv
// eth_mac_regs: AXI-Lite register file for MAC unicast address and control; read channel present only with ETH_REGS_READ_EN
module eth_mac_regs
   import eth_regs_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h40C0_0000,
   parameter logic [47:0] RESET_MAC = 48'h0
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [31:0] S_AXI_AWADDR,
   input  logic        S_AXI_AWVALID,
   output logic        S_AXI_AWREADY,
   input  logic [31:0] S_AXI_WDATA,
   input  logic [3:0]  S_AXI_WSTRB,
   input  logic        S_AXI_WVALID,
   output logic        S_AXI_WREADY,
   output logic [1:0]  S_AXI_BRESP,
   output logic        S_AXI_BVALID,
   input  logic        S_AXI_BREADY,
   input  logic [31:0] S_AXI_ARADDR,
   input  logic        S_AXI_ARVALID,
   output logic        S_AXI_ARREADY,
   output logic [31:0] S_AXI_RDATA,
   output logic [1:0]  S_AXI_RRESP,
   output logic        S_AXI_RVALID,
   input  logic        S_AXI_RREADY,
   output logic [47:0] mac_addr,
   output logic        mac_rx_en,
   output logic        mac_tx_en,
   output logic        mac_addr_upd
);
   logic commit;
   logic [11:0] c_addr;
   logic [31:0] c_data, cur, wr_val, uwa0;
   logic [3:0] c_strb;
   logic [15:0] uwa1, wr_count;
   logic [1:0] ctrl, bresp;
   logic wr_ok;
   wr_state_t wr_state, wr_next;
   axil_wr_capture u_cap (
      .aclk(aclk),
      .aresetn(aresetn),
      .awaddr(S_AXI_AWADDR[11:0]),
      .awvalid(S_AXI_AWVALID),
      .awready(S_AXI_AWREADY),
      .wdata(S_AXI_WDATA),
      .wstrb(S_AXI_WSTRB),
      .wvalid(S_AXI_WVALID),
      .wready(S_AXI_WREADY),
      .busy(S_AXI_BVALID),
      .commit(commit),
      .addr(c_addr),
      .data(c_data),
      .strb(c_strb)
   );
   assign mac_addr = {uwa1, uwa0};
   assign mac_rx_en = ctrl[CTRL_RX_BIT];
   assign mac_tx_en = ctrl[CTRL_TX_BIT];
   assign S_AXI_BVALID = wr_state == W_RESP;
   assign S_AXI_BRESP = bresp;
   // decode the held write and merge its strobed bytes into the current register value
   always_comb begin
      wr_ok = c_addr == UWA0_OFS || c_addr == UWA1_OFS || c_addr == CTRL_OFS;
      cur = c_addr == UWA0_OFS ? uwa0 : c_addr == UWA1_OFS ? {16'h0, uwa1} : {30'h0, ctrl};
      wr_val = merge_bytes(cur, c_data, c_strb);
   end
   // write FSM next state: respond after commit, release on B handshake
   always_comb begin
      wr_next = wr_state;
      if (wr_state == W_IDLE) wr_next = commit ? W_RESP : W_IDLE;
      else wr_next = S_AXI_BREADY ? W_IDLE : W_RESP;
   end
   // write FSM state register
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) wr_state <= W_IDLE;
      else wr_state <= wr_next;
   // register file update, write counter, response code and address-update strobe
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         uwa0 <= RESET_MAC[31:0];
         uwa1 <= RESET_MAC[47:32];
         ctrl <= '0;
         wr_count <= '0;
         bresp <= RESP_OKAY;
         mac_addr_upd <= 1'b0;
      end else begin
         mac_addr_upd <= commit && wr_ok && c_addr == UWA1_OFS;
         if (commit) bresp <= wr_ok ? RESP_OKAY : RESP_SLVERR;
         if (commit && wr_ok) begin
            wr_count <= wr_count + 16'd1;
            if (c_addr == UWA0_OFS) uwa0 <= wr_val;
            if (c_addr == UWA1_OFS) uwa1 <= wr_val[15:0];
            if (c_addr == CTRL_OFS) ctrl <= wr_val[1:0];
         end
      end
`ifdef ETH_REGS_READ_EN
   logic unused;
   logic [11:0] ar_ofs;
   logic [31:0] rd_data;
   logic [1:0] rd_resp;
   rd_state_t rd_state, rd_next;
   assign unused = ^{BASE_ADDR, S_AXI_AWADDR[31:12], S_AXI_ARADDR[31:12]};
   assign ar_ofs = S_AXI_ARADDR[11:0];
   assign S_AXI_ARREADY = aresetn && S_AXI_ARVALID && rd_state == R_IDLE;
   assign S_AXI_RVALID = rd_state == R_DATA;
   // read decode; unmapped or misaligned offsets return zero with SLVERR
   always_comb begin
      rd_data = ar_ofs == UWA0_OFS ? uwa0 : ar_ofs == UWA1_OFS ? {16'h0, uwa1} : ar_ofs == CTRL_OFS ? {30'h0, ctrl} : ar_ofs == STAT_OFS ? {16'h0, wr_count} : 32'h0;
      rd_resp = (ar_ofs == UWA0_OFS || ar_ofs == UWA1_OFS || ar_ofs == CTRL_OFS || ar_ofs == STAT_OFS) ? RESP_OKAY : RESP_SLVERR;
   end
   // read FSM next state: one outstanding read, held until R handshake
   always_comb begin
      rd_next = rd_state;
      if (rd_state == R_IDLE) rd_next = S_AXI_ARREADY ? R_DATA : R_IDLE;
      else rd_next = S_AXI_RREADY ? R_IDLE : R_DATA;
   end
   // read FSM state and read data register; data sampled before any same-edge commit
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         rd_state <= R_IDLE;
         S_AXI_RDATA <= '0;
         S_AXI_RRESP <= RESP_OKAY;
      end else begin
         rd_state <= rd_next;
         if (S_AXI_ARREADY) begin
            S_AXI_RDATA <= rd_data;
            S_AXI_RRESP <= rd_resp;
         end
      end
`else
   logic unused;
   assign unused = ^{BASE_ADDR, S_AXI_AWADDR[31:12], S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY, wr_count};
   assign S_AXI_ARREADY = 1'b0;
   assign S_AXI_RVALID = 1'b0;
   assign S_AXI_RDATA = '0;
   assign S_AXI_RRESP = '0;
`endif
endmodule
